// File: rtl/control_sequencer.sv
// Instruction-issue control sequencer: decodes accepted instructions into one-cycle
// registered control strobes, stalls issue across multi-cycle loads, and halts sticky.
module control_sequencer #(
  parameter int IW       = 9,
  parameter int OPW      = 4,
  parameter int LOAD_LAT = 2,
  parameter int CNTW     = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            InstValid,
  input  logic [IW-1:0]   Inst,
  input  logic [1:0]      CmpResult,
  output logic            InstReady,
  output logic            Reg0Write,
  output logic            GenPurpRegWrite,
  output logic            WriteMem,
  output logic            Branch,
  output logic            MemToReg,
  output logic            Halted,
  output logic            Busy,
  output logic [CNTW-1:0] InstCount
);

  // Counter only needs to hold LOAD_LAT-1, the number of stalled cycles.
  localparam int LCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_LOAD_WAIT = 2'd2,
    S_HALTED    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      flag_q, flag_d;
  logic [LCW-1:0]  lw_cnt_q, lw_cnt_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            r0w_q, r0w_d;
  logic            gpr_q, gpr_d;
  logic            wm_q, wm_d;
  logic            br_q, br_d;
  logic            mtr_q, mtr_d;

  logic [OPW-1:0]  op;
  logic [3:0]      op4;
  logic            op_valid;
  logic            accept;
  logic            unused_inst;

  assign op          = Inst[IW-1 -: OPW];
  assign op4         = op[3:0];
  // Wide opcodes above 4'hF decode to nothing but still count as accepted.
  assign op_valid    = (op <= OPW'(15));
  assign accept      = InstValid && (state_q == S_RUN);
  assign unused_inst = ^Inst[IW-OPW-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      flag_q   <= 2'b11;
      lw_cnt_q <= '0;
      cnt_q    <= '0;
      r0w_q    <= 1'b0;
      gpr_q    <= 1'b0;
      wm_q     <= 1'b0;
      br_q     <= 1'b0;
      mtr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      lw_cnt_q <= lw_cnt_d;
      cnt_q    <= cnt_d;
      r0w_q    <= r0w_d;
      gpr_q    <= gpr_d;
      wm_q     <= wm_d;
      br_q     <= br_d;
      mtr_q    <= mtr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    lw_cnt_d = lw_cnt_q;
    cnt_d    = cnt_q;
    r0w_d    = 1'b0;
    gpr_d    = 1'b0;
    wm_d     = 1'b0;
    br_d     = 1'b0;
    mtr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_RUN;
      end

      S_RUN: begin
        if (accept) begin
          if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + CNTW'(1);
          if (op_valid) begin
            case (op4)
              4'h0, 4'h1, 4'h2, 4'h3, 4'h4: r0w_d = 1'b1;
              4'h5, 4'h6, 4'h8:             gpr_d = 1'b1;
              4'h7:                         flag_d = CmpResult;
              4'h9: br_d = (flag_q == 2'b10);
              4'hA: br_d = (flag_q == 2'b01) || (flag_q == 2'b10);
              4'hB: br_d = (flag_q == 2'b00) || (flag_q == 2'b10);
              4'hC: br_d = 1'b1;
              4'hD: wm_d = 1'b1;
              4'hE: begin
                mtr_d = 1'b1;
                if (LOAD_LAT == 1) begin
                  gpr_d = 1'b1;
                end else begin
                  state_d  = S_LOAD_WAIT;
                  lw_cnt_d = LCW'(LOAD_LAT - 1);
                end
              end
              default: state_d = S_HALTED;
            endcase
          end
        end
      end

      S_LOAD_WAIT: begin
        // Final stalled cycle launches the writeback strobe and reopens issue.
        mtr_d = 1'b1;
        if (lw_cnt_q <= LCW'(1)) begin
          gpr_d    = 1'b1;
          lw_cnt_d = '0;
          state_d  = S_RUN;
        end else begin
          lw_cnt_d = lw_cnt_q - LCW'(1);
        end
      end

      default: ;
    endcase
  end

  assign InstReady       = (state_q == S_RUN);
  assign Busy            = (state_q == S_RUN) || (state_q == S_LOAD_WAIT);
  assign Halted          = (state_q == S_HALTED);
  assign InstCount       = cnt_q;
  assign Reg0Write       = r0w_q;
  assign GenPurpRegWrite = gpr_q;
  assign WriteMem        = wm_q;
  assign Branch          = br_q;
  assign MemToReg        = mtr_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer built with LOAD_LAT=3 and CNTW=4.
module tb_control_sequencer;

  localparam int IW = 9, OPW = 4, LOAD_LAT = 3, CNTW = 4;

  logic            Clk = 1'b0;
  logic            Reset, Start, InstValid;
  logic [IW-1:0]   Inst;
  logic [1:0]      CmpResult;
  logic            InstReady, Reg0Write, GenPurpRegWrite, WriteMem, Branch, MemToReg, Halted, Busy;
  logic [CNTW-1:0] InstCount;

  int n_chk  = 0;
  int n_fail = 0;

  control_sequencer #(.IW(IW), .OPW(OPW), .LOAD_LAT(LOAD_LAT), .CNTW(CNTW)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstValid(InstValid), .Inst(Inst),
    .CmpResult(CmpResult), .InstReady(InstReady), .Reg0Write(Reg0Write),
    .GenPurpRegWrite(GenPurpRegWrite), .WriteMem(WriteMem), .Branch(Branch),
    .MemToReg(MemToReg), .Halted(Halted), .Busy(Busy), .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [IW-1:0] ins(input logic [3:0] op);
    return {op, 5'b0};
  endfunction

  // Packed view of the five strobes: {Reg0Write, GPRW, WriteMem, Branch, MemToReg}
  function automatic logic [31:0] strb();
    return {27'b0, Reg0Write, GenPurpRegWrite, WriteMem, Branch, MemToReg};
  endfunction

  task automatic issue(input logic [3:0] op);
    Inst = ins(op);
    InstValid = 1'b1;
    tick;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; InstValid = 1'b0; Inst = '0; CmpResult = 2'b11;
    tick; tick;
    chk("rst_strobes", strb(), 32'h0);
    chk("rst_ready", InstReady, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_halted", Halted, 1'b0);
    chk("rst_count", InstCount, 4'h0);
    Reset = 1'b0;

    // IDLE ignores a presented instruction until Start
    InstValid = 1'b1; Inst = ins(4'h2);
    tick;
    chk("idle_no_accept", InstCount, 4'h0);
    InstValid = 1'b0;
    Start = 1'b1; tick; Start = 1'b0;
    chk("run_ready", InstReady, 1'b1);
    chk("run_busy", Busy, 1'b1);

    // ADD 9'h040
    Inst = 9'h040; InstValid = 1'b1; tick; InstValid = 1'b0;
    chk("add_r0w", strb(), 32'h10);
    chk("add_count", InstCount, 4'h1);
    tick;
    chk("add_r0w_one_cycle", strb(), 32'h0);

    // flag resets to 11: BGE not taken
    issue(4'hA);
    chk("bge_flag11", Branch, 1'b0);

    // CMP equal then BEQ
    CmpResult = 2'b10;
    issue(4'h7);
    chk("cmp_no_strobe", strb(), 32'h0);
    CmpResult = 2'b11;
    issue(4'h9);
    chk("beq_eq_taken", strb(), 32'h02);

    // CMP greater: BEQ untaken, BGE taken, BLE untaken
    CmpResult = 2'b01;
    issue(4'h7);
    CmpResult = 2'b00;
    issue(4'h9);
    chk("beq_gt_untaken", strb(), 32'h0);
    issue(4'hA);
    chk("bge_gt_taken", strb(), 32'h02);
    issue(4'hB);
    chk("ble_gt_untaken", strb(), 32'h0);

    issue(4'h5);
    chk("mov3_gpr", strb(), 32'h08);
    issue(4'hD);
    chk("store_wm", strb(), 32'h04);
    issue(4'hC);
    chk("br_taken", strb(), 32'h02);
    chk("count_11", InstCount, 4'hB);

    // LOAD with InstValid held, followed by ADD waiting for ready
    issue(4'hE);
    Inst = ins(4'h2);
    chk("ld_n1_ready", InstReady, 1'b0);
    chk("ld_n1_strb", strb(), 32'h01);
    chk("ld_n1_busy", Busy, 1'b1);
    tick;
    chk("ld_n2_ready", InstReady, 1'b0);
    chk("ld_n2_strb", strb(), 32'h01);
    tick;
    chk("ld_n3_ready", InstReady, 1'b1);
    chk("ld_n3_strb", strb(), 32'h09);
    tick; InstValid = 1'b0;
    chk("ld_n4_add", strb(), 32'h10);
    chk("ld_count", InstCount, 4'hD);

    // Reset mid-LOAD_WAIT
    issue(4'hE); InstValid = 1'b0;
    chk("lw_busy", Busy, 1'b1);
    Reset = 1'b1; tick; Reset = 1'b0;
    chk("lwrst_strb", strb(), 32'h0);
    chk("lwrst_ready", InstReady, 1'b0);
    chk("lwrst_busy", Busy, 1'b0);
    chk("lwrst_count", InstCount, 4'h0);
    Inst = ins(4'h2); InstValid = 1'b1; tick;
    chk("lwrst_need_start", {InstCount, Reg0Write}, {4'h0, 1'b0});
    Start = 1'b1; tick; Start = 1'b0;
    tick; InstValid = 1'b0;
    chk("restart_add", {InstCount, Reg0Write}, {4'h1, 1'b1});

    // HALT: sticky, ignores Start and instructions, count frozen
    issue(4'hF);
    chk("halt_halted", Halted, 1'b1);
    chk("halt_no_strobe", strb(), 32'h0);
    chk("halt_count", InstCount, 4'h2);
    Inst = ins(4'h2); InstValid = 1'b1; Start = 1'b1;
    tick; tick; tick;
    Start = 1'b0; InstValid = 1'b0;
    chk("halt_sticky", {Halted, InstReady, Busy}, 3'b100);
    chk("halt_frozen", InstCount, 4'h2);
    chk("halt_no_strb2", strb(), 32'h0);

    // Saturation: 17 accepts into a 4-bit counter
    Reset = 1'b1; tick; Reset = 1'b0;
    Start = 1'b1; tick; Start = 1'b0;
    Inst = ins(4'h1); InstValid = 1'b1;
    for (int i = 0; i < 16; i++) tick;
    chk("sat_16", InstCount, 4'hF);
    tick;
    chk("sat_17", InstCount, 4'hF);
    tick;
    chk("sat_hold", InstCount, 4'hF);
    InstValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter IW, default 9, meaning instruction width in bits.
REQ-002 The block SHALL have parameter OPW, default 4, meaning opcode width; opcode = Inst[IW-1 -: OPW]; OPW >= 4.
REQ-003 The block SHALL have parameter LOAD_LAT, default 2, meaning data-memory read latency in cycles; LOAD_LAT >= 1.
REQ-004 The block SHALL have parameter CNTW, default 16, meaning retired-instruction counter width.
REQ-005 Clk  input  1  clock; all state updates on the rising edge.
REQ-006 Reset  input  1  reset; synchronous, active-high.
REQ-007 Start  input  1  one-cycle request to leave IDLE.
REQ-008 InstValid  input  1  Inst is valid this cycle.
REQ-009 Inst  input  IW  instruction word.
REQ-010 CmpResult  input  2  ALU compare result: 00 less, 01 greater, 10 equal, 11 none.
REQ-011 InstReady  output  1  sequencer accepts Inst this cycle.
REQ-012 Reg0Write, GenPurpRegWrite, WriteMem, Branch, MemToReg  output  1 each  registered control strobes.
REQ-013 Halted  output  1  sticky halt indication.
REQ-014 Busy  output  1  high in any state except IDLE and HALTED.
REQ-015 InstCount  output  CNTW  number of accepted instructions.

Function
REQ-016 Accept SHALL occur on a cycle where InstValid && InstReady; no other cycle changes decode state.
REQ-017 FSM states SHALL be IDLE, RUN, LOAD_WAIT, HALTED; InstReady = 1 only in RUN.
REQ-018 IDLE -> RUN when Start=1; Start in any other state SHALL be ignored.
REQ-019 Opcode map SHALL be: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 ADDI, 5 MOV3, 6 MOV2, 7 CMP, 8 SHIFT, 9 BEQ, A BGE, B BLE, C BR, D STORE, E LOAD, F HALT; values above F (OPW > 4) SHALL be no-ops.
REQ-020 Strobes SHALL be registered: for an instruction accepted in cycle N they are high in cycle N+1 only, low otherwise.
REQ-021 Opcodes 0-4 -> Reg0Write; 5, 6, 8 -> GenPurpRegWrite; D -> WriteMem; C -> Branch; 7 and no-ops -> no strobe.
REQ-022 Flag register SHALL load CmpResult on a CMP accept; a branch accepted on any later cycle uses the updated value.
REQ-023 Branch conditions on the flag register: BEQ flag==10; BGE flag==01 or 10; BLE flag==00 or 10; an untaken branch produces no strobe.
REQ-024 LOAD accepted in cycle N: MemToReg high cycles N+1..N+LOAD_LAT; GenPurpRegWrite high in cycle N+LOAD_LAT only; state LOAD_WAIT for cycles N+1..N+LOAD_LAT-1 (skipped when LOAD_LAT=1); next accept no earlier than N+LOAD_LAT.
REQ-025 HALT accept SHALL enter HALTED; Halted high from cycle N+1 until Reset; no further accepts, strobes or counting.
REQ-026 InstCount SHALL increment by 1 per accept (HALT included) and saturate at all-ones.
REQ-027 While InstReady=0, Inst/InstValid SHALL be ignored; the instruction is accepted when InstReady returns if still presented.

Reset
REQ-028 Reset SHALL force IDLE, all strobes 0, InstReady 0, Halted 0, Busy 0, InstCount 0, flag register 11, LOAD_WAIT counter 0.
REQ-029 Reset SHALL take priority over Start, accept and all in-flight LOAD/HALT effects, including mid-LOAD_WAIT.

Verification
REQ-030 Reset, Start, ADD (Inst=9'h040) accepted at cycle N -> Reg0Write=1 at N+1 only, InstCount=1.
REQ-031 CMP with CmpResult=10, then BEQ next cycle -> Branch=1; repeat with CmpResult=01 -> BEQ no Branch, BGE Branch=1.
REQ-032 LOAD_LAT=3, LOAD at N with InstValid held -> InstReady 0 at N+1,N+2; MemToReg N+1..N+3; GenPurpRegWrite N+3 only; next accept N+3.
REQ-033 HALT accepted -> Halted=1 next cycle and stays; subsequent InstValid and Start ignored; InstCount frozen.
REQ-034 Reset asserted during LOAD_WAIT -> next cycle all outputs 0, state IDLE; Start needed before next accept.
REQ-035 CNTW=4, 17 accepted non-HALT instructions -> InstCount=4'hF.
